// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit for the E stage: signed/unsigned mult, div,
// multiply-accumulate/subtract and mthi/mtlo, with busy stall and done pulse.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_launch;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic [2*WIDTH-1:0] w_result;

    logic [2*WIDTH-1:0] w_ea;
    logic [2*WIDTH-1:0] w_eb;
    logic [2*WIDTH-1:0] w_ps;
    logic [2*WIDTH-1:0] w_pu;
    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;
    logic signed [WIDTH-1:0] w_sq;
    logic signed [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic               w_dz;
    logic               w_ovf;

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    // Products are formed at 2*WIDTH so the truncated result is exact modulo 2^(2*WIDTH)
    assign w_ea = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_eb = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_ps = w_ea * w_eb;
    assign w_pu = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    assign w_sa  = r_a;
    assign w_sb  = r_b;
    assign w_sq  = w_sa / w_sb;
    assign w_sr  = w_sa % w_sb;
    assign w_uq  = r_a / r_b;
    assign w_ur  = r_a % r_b;
    assign w_dz  = (r_b == '0);
    assign w_ovf = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);

    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            4'd1: w_result = w_ps;
            4'd2: w_result = w_pu;
            4'd3: begin
                if (w_dz)       w_result = {r_a, {WIDTH{1'b1}}};
                else if (w_ovf) w_result = {{WIDTH{1'b0}}, r_a};
                else            w_result = {w_sr, w_sq};
            end
            4'd4: begin
                if (w_dz) w_result = {r_a, {WIDTH{1'b1}}};
                else      w_result = {w_ur, w_uq};
            end
            4'd5: w_result = r_acc + w_ps;
            4'd6: w_result = r_acc + w_pu;
            4'd7: w_result = r_acc - w_ps;
            4'd8: w_result = r_acc - w_pu;
            default: w_result = {r_hi, r_lo};
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_commit = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
                            w_next   = S_MUL;
                            w_launch = 1'b1;
                        end
                        4'd3, 4'd4: begin
                            w_next   = S_DIV;
                            w_launch = 1'b1;
                        end
                        4'd9:    w_wr_hi = 1'b1;
                        4'd10:   w_wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == CW'(1)) begin
                    w_next   = S_IDLE;
                    w_commit = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_commit;
            if (w_launch) begin
                r_a   <= D1;
                r_b   <= D2;
                r_op  <= op;
                r_acc <= {r_hi, r_lo};
                r_cnt <= (w_next == S_MUL) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit) {r_hi, r_lo} <= w_result;
            if (w_wr_hi)  r_hi <= D1;
            if (w_wr_lo)  r_lo <= D1;
        end
    end
endmodule

// File: tb/tb_md_unit_param.sv
// Randomised self-checking bench for md_unit_param: a 32-bit default instance and a
// 16-bit fast instance, both checked against a transaction-level arithmetic model.
module tb_md_unit_param;
    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        sel;

    logic [31:0] hi32, lo32;
    logic        busy32, done32;
    logic [15:0] hi16, lo16;
    logic        busy16, done16;
    logic        start32, start16;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o;

    int checks;
    int fails;
    logic [31:0] m_hi, m_lo;

    assign start32 = start & ~sel;
    assign start16 = start & sel;
    assign hi_o    = sel ? {16'h0, hi16} : hi32;
    assign lo_o    = sel ? {16'h0, lo16} : lo32;
    assign busy_o  = sel ? busy16 : busy32;
    assign done_o  = sel ? done16 : done32;

    md_unit_param u_md32 (
        .clk(clk), .reset(reset), .start(start32), .op(op), .D1(d1), .D2(d2),
        .HI(hi32), .LO(lo32), .busy(busy32), .done(done32)
    );

    md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_md16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .D1(d1[15:0]), .D2(d2[15:0]),
        .HI(hi16), .LO(lo16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cur_w();
        return sel ? 16 : 32;
    endfunction

    function automatic int latency(input logic [3:0] o);
        if (o == 4'd1 || o == 4'd2 || (o >= 4'd5 && o <= 4'd8)) return sel ? 1 : 5;
        if (o == 4'd3 || o == 4'd4) return sel ? 3 : 10;
        return 0;
    endfunction

    // Arithmetic reference: magnitudes for signed division, 64-bit modular math for products
    function automatic void model(input int w, input logic [3:0] o,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rhi, output logic [31:0] rlo);
        logic [63:0] mw, m2, aa, bb, sa, sb, acc, res, ma, mb, q, r;
        logic na, nb;
        mw  = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
        m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        aa  = {32'h0, a} & mw;
        bb  = {32'h0, b} & mw;
        na  = aa[w-1];
        nb  = bb[w-1];
        sa  = na ? (aa | ~mw) : aa;
        sb  = nb ? (bb | ~mw) : bb;
        acc = ((({32'h0, hi}) & mw) << w) | ({32'h0, lo} & mw);
        res = acc;
        case (o)
            4'd1: res = (sa * sb) & m2;
            4'd2: res = (aa * bb) & m2;
            4'd5: res = (acc + sa * sb) & m2;
            4'd6: res = (acc + aa * bb) & m2;
            4'd7: res = (acc - sa * sb) & m2;
            4'd8: res = (acc - aa * bb) & m2;
            4'd3: begin
                if (bb == 0) res = (aa << w) | mw;
                else if (aa == (64'd1 << (w - 1)) && bb == mw) res = aa;
                else begin
                    ma = na ? -sa : aa;
                    mb = nb ? -sb : bb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if (na != nb) q = -q;
                    if (na) r = -r;
                    res = ((r & mw) << w) | (q & mw);
                end
            end
            4'd4: begin
                if (bb == 0) res = (aa << w) | mw;
                else res = (((aa % bb) & mw) << w) | ((aa / bb) & mw);
            end
            4'd9:  res = (aa << w) | (acc & mw);
            4'd10: res = (acc & (mw << w)) | aa;
            default: res = acc;
        endcase
        rhi = 32'((res >> w) & mw);
        rlo = 32'(res & mw);
    endfunction

    function automatic logic [31:0] rnd_val();
        int unsigned k;
        logic [31:0] mw;
        mw = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        k  = $urandom_range(0, 9);
        case (k)
            0: return 32'h0;
            1: return 32'h1;
            2: return mw;
            3: return sel ? 32'h0000_8000 : 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom & mw;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b);
        logic [31:0] eh, el;
        int n, exp_n;
        bit fin;
        if (!b2b) begin
            @(negedge clk);
            chk("done_idle", done_o, 0);
        end
        model(cur_w(), o, m_hi, m_lo, a, b, eh, el);
        exp_n = latency(o);
        start = 1'b1; op = o; d1 = a; d2 = b;
        n = 0; fin = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (busy_o) begin
                n++;
                chk("hi_hold", hi_o, m_hi);
                chk("lo_hold", lo_o, m_lo);
                chk("done_busy", done_o, 0);
                start = 1'($urandom_range(0, 1));
                op    = 4'($urandom_range(0, 15));
                d1    = $urandom;
                d2    = $urandom;
            end else begin
                fin = 1;
            end
        end
        start = 1'b0; op = 4'd0;
        chk("busy_cycles", n, exp_n);
        chk("hi", hi_o, eh);
        chk("lo", lo_o, el);
        chk("done_pulse", done_o, (exp_n > 0) ? 1 : 0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; op = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b1; start = 1'b0; op = 4'd0; d1 = 0; d2 = 0; sel = 1'b0;
        m_hi = 0; m_lo = 0;
        do_reset();

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        chk("tp1_hi", hi_o, 32'h1);
        chk("tp1_lo", lo_o, 32'hFFFF_FFFE);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        chk("tp2_lo", lo_o, 32'hFFFF_FFFD);
        chk("tp2_hi", hi_o, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd0, 0);
        chk("dz_lo", lo_o, 32'hFFFF_FFFF);
        chk("dz_hi", hi_o, 32'd7);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("ovf_lo", lo_o, 32'h8000_0000);
        chk("ovf_hi", hi_o, 32'h0);
        run_op(4'd9, 32'd0, 32'd0, 0);
        run_op(4'd10, 32'd10, 32'd0, 0);
        run_op(4'd5, 32'hFFFF_FFFE, 32'd3, 0);
        chk("madd_hi", hi_o, 32'h0);
        chk("madd_lo", lo_o, 32'd4);
        run_op(4'd8, 32'd5, 32'd1, 0);
        chk("msubu_hi", hi_o, 32'hFFFF_FFFF);
        chk("msubu_lo", lo_o, 32'hFFFF_FFFF);
        run_op(4'd9, 32'd0, 32'd0, 0);
        run_op(4'd1, 32'd3, 32'd4, 0);
        chk("tp4_lo", lo_o, 32'd12);
        run_op(4'd1, 32'd5, 32'd6, 1);
        chk("b2b_lo", lo_o, 32'd30);

        for (int i = 0; i < 40; i++)
            run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0));

        // Abort a divide mid-flight with HI/LO holding non-zero values
        run_op(4'd9, 32'h1234, 32'd0, 0);
        run_op(4'd10, 32'h5678, 32'd0, 0);
        @(negedge clk);
        start = 1'b1; op = 4'd4; d1 = 32'd100; d2 = 32'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("abort_busy_pre", busy_o, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        chk("abort_hi", hi_o, 0);
        chk("abort_lo", lo_o, 0);
        chk("abort_busy", busy_o, 0);
        for (int k = 0; k < 12; k++) begin
            chk("abort_done", done_o, 0);
            @(negedge clk);
        end
        run_op(4'd1, 32'd7, 32'hFFFF_FFFF, 0);
        chk("post_abort_hi", hi_o, 32'hFFFF_FFFF);
        chk("post_abort_lo", lo_o, 32'hFFFF_FFF9);

        sel = 1'b1;
        do_reset();
        run_op(4'd1, 32'h8000, 32'h2, 0);
        chk("w16_mult_hi", hi_o, 32'hFFFF);
        chk("w16_mult_lo", lo_o, 32'h0);
        run_op(4'd4, 32'd100, 32'd7, 0);
        chk("w16_divu_lo", lo_o, 32'd14);
        chk("w16_divu_hi", hi_o, 32'd2);
        for (int i = 0; i < 30; i++)
            run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
